transmissor_paridade: RTL
=========================

// Module: transmissor_paridade
//
// PURPOSE
//   Serial transmitter that pairs with the 9-bit even-parity checker.
//   Accepts an 8-bit word over a valid/ready handshake and computes the parity bit.
//   Shifts out one frame on tx: start(0), 8 data bits LSB first, parity, stop(1).
//   Also presents the registered 9-bit word {parity, data} on quadro, in the same
//   layout the checker expects (parity in bit 8), for parallel loopback.
//
// PARAMETERS
//   CLKS_PER_BIT   4   clock cycles each serial bit is held on tx; legal range >= 1
//   PARIDADE_IMPAR 0   0: even parity (XOR of quadro[8:0] == 0); 1: odd parity (bit 8 inverted)
//
// PORTS
//   clk       in   1  single clock; all state updates on rising edge
//   rst       in   1  asynchronous, active-high reset
//   dado_in   in   8  word to send; sampled only at handshake
//   valido    in   1  producer has a word on dado_in
//   pronto    out  1  block can accept a word (high only in IDLE)
//   tx        out  1  serial line; idles high
//   ocupado   out  1  a frame is in progress (any state except IDLE)
//   quadro    out  9  {parity, data} of the last accepted word
//
// BEHAVIOUR
//   Reset values (rst high, takes effect immediately, asynchronous):
//     state=IDLE, tx=1, pronto=1, ocupado=0, quadro=0, bit/baud counters=0.
//   Handshake:
//     - A word is accepted on a rising edge where valido && pronto.
//     - On that edge: quadro <= {par, dado_in}, with par = ^dado_in ^ PARIDADE_IMPAR.
//     - dado_in and valido are ignored while ocupado=1.
//   States: IDLE -> START -> DATA -> PARIDADE -> STOP -> IDLE.
//     - IDLE:     tx=1, pronto=1. Goes to START on handshake.
//     - START:    tx=0 for CLKS_PER_BIT cycles.
//     - DATA:     tx=quadro[idx]; idx runs 0..7, each held CLKS_PER_BIT cycles.
//                 Goes to PARIDADE after idx 7 is done.
//     - PARIDADE: tx=quadro[8] for CLKS_PER_BIT cycles.
//     - STOP:     tx=1 for CLKS_PER_BIT cycles, then IDLE.
//   Timing:
//     - tx is registered. First start-bit cycle is the cycle after the handshake edge.
//     - Frame length is exactly 11*CLKS_PER_BIT cycles.
//     - pronto goes high on the cycle after the last stop cycle.
//   Back-to-back: pronto is high for at least 1 cycle between frames. A valido that
//     is held high is accepted on that first IDLE cycle. No gap is added beyond the stop bit.
//   Counters:
//     - Baud counter width is max(1, $clog2(CLKS_PER_BIT)).
//     - It counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
//     - Bit index is 3 bits. With CLKS_PER_BIT=1 every state lasts 1 cycle.
//   Reset mid-frame: the frame is abandoned, tx returns high at once, and quadro is cleared.
//     No partial frame resumes after rst is released.
//   quadro holds its value until the next handshake; it is not cleared at end of frame.
//
// STRUCTURE
//   Shared package (paridade_pkg):
//     - state encoding localparams: IDLE, START, DATA, PARIDADE, STOP
//     - N_BITS_DADO=8, N_BITS_QUADRO=11
//   Sub-module gerador_paridade: combinational, input [7:0] dado, parameter
//     PARIDADE_IMPAR, output par. It is the mirror of the checker and is reused by the TB.
//   Top: one FSM, one baud counter, one bit-index counter, registers for quadro and tx.
//
// TESTING
//   1. Reset, then valido=1 with dado_in=8'hA5 (CLKS_PER_BIT=4):
//      quadro=9'h0A5; tx = 0,1,0,1,0,0,1,0,1,0,1, each bit 4 cycles, 44 cycles total.
//   2. dado_in=8'h07: quadro=9'h107; parity bit on tx is 1.
//      With PARIDADE_IMPAR=1: quadro=9'h007.
//   3. valido held high with 8'h00 then 8'hFF: second start bit begins 1 idle cycle after
//      the first stop. Both parity bits are 0.
//   4. Assert rst mid-DATA: tx=1 in the same cycle, pronto=1, ocupado=0, quadro=0.
//      A new 8'h3C after release sends a complete, correct frame.
//   5. Loopback, all 256 values: quadro feeds the checker and erro must be 0.
//      Flipping any single quadro bit must give erro=1.
//   6. Toggle valido and dado_in randomly while ocupado=1: the frame in progress and
//      quadro must not change.

Source files
------------

// File: rtl/paridade_pkg.sv
// rtl/paridade_pkg.sv - shared types and sizes for the parity transmitter
package paridade_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    PARIDADE = 3'd3,
    STOP     = 3'd4
  } estado_t;

  localparam int N_BITS_DADO   = 8;
  localparam int N_BITS_QUADRO = 11;

  // Baud counter must stay at least one bit wide even when every bit lasts one cycle
  function automatic int baud_width(input int clks_per_bit);
    return (clks_per_bit <= 2) ? 1 : $clog2(clks_per_bit);
  endfunction

endpackage

// File: rtl/gerador_paridade.sv
// rtl/gerador_paridade.sv - combinational parity generator, mirror of the 9-bit checker
module gerador_paridade
  import paridade_pkg::*;
#(
  parameter int PARIDADE_IMPAR = 0
) (
  input  logic [N_BITS_DADO-1:0] dado,
  output logic                   par
);

  assign par = (^dado) ^ (PARIDADE_IMPAR != 0);

endmodule

// File: rtl/transmissor_paridade.sv
// rtl/transmissor_paridade.sv - serial frame transmitter: start, 8 data LSB first, parity, stop
module transmissor_paridade
  import paridade_pkg::*;
#(
  parameter int CLKS_PER_BIT   = 4,
  parameter int PARIDADE_IMPAR = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_BITS_DADO-1:0] dado_in,
  input  logic                   valido,
  output logic                   pronto,
  output logic                   tx,
  output logic                   ocupado,
  output logic [N_BITS_DADO:0]   quadro
);

  localparam int             BW       = baud_width(CLKS_PER_BIT);
  localparam logic [BW-1:0]  BAUD_ULT = BW'(CLKS_PER_BIT - 1);

  estado_t                estado_q, estado_d;
  logic [BW-1:0]          baud_q, baud_d;
  logic [2:0]             idx_q, idx_d;
  logic                   tx_q, tx_d;
  logic                   pronto_q, pronto_d;
  logic [N_BITS_DADO:0]   quadro_q, quadro_d;
  logic                   par;

  gerador_paridade #(
    .PARIDADE_IMPAR(PARIDADE_IMPAR)
  ) u_gerador (
    .dado(dado_in),
    .par (par)
  );

  always_comb begin
    estado_d = estado_q;
    baud_d   = baud_q;
    idx_d    = idx_q;
    quadro_d = quadro_q;

    if (estado_q == IDLE) begin
      baud_d = '0;
      idx_d  = '0;
      if (valido && pronto_q) begin
        quadro_d = {par, dado_in};
        estado_d = START;
      end
    end else if (baud_q != BAUD_ULT) begin
      baud_d = baud_q + 1'b1;
    end else begin
      baud_d = '0;
      case (estado_q)
        START:    estado_d = DATA;
        DATA:     if (idx_q == 3'd7) estado_d = PARIDADE;
                  else idx_d = idx_q + 3'd1;
        PARIDADE: estado_d = STOP;
        STOP:     estado_d = IDLE;
        default:  estado_d = IDLE;
      endcase
    end

    // tx is registered, so it is derived from the state being entered
    case (estado_d)
      START:    tx_d = 1'b0;
      DATA:     tx_d = quadro_d[idx_d];
      PARIDADE: tx_d = quadro_d[N_BITS_DADO];
      default:  tx_d = 1'b1;
    endcase

    pronto_d = (estado_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q <= IDLE;
      baud_q   <= '0;
      idx_q    <= '0;
      tx_q     <= 1'b1;
      pronto_q <= 1'b1;
      quadro_q <= '0;
    end else begin
      estado_q <= estado_d;
      baud_q   <= baud_d;
      idx_q    <= idx_d;
      tx_q     <= tx_d;
      pronto_q <= pronto_d;
      quadro_q <= quadro_d;
    end
  end

  assign tx      = tx_q;
  assign pronto  = pronto_q;
  assign ocupado = ~pronto_q;
  assign quadro  = quadro_q;

endmodule
